clk_gate_ctrl: RTL and testbench
================================

// Module: clk_gate_ctrl
// PURPOSE
//   Idle-detect controller that drives the EN/TE inputs of GATED_CLK_CELL.
//   Sits in the always-on CLK_IN domain next to each gateable unit.
//   Counts consecutive idle cycles of the unit and gates its clock after a
//   programmable threshold. Ungates on demand and returns a WAKE_ACK
//   handshake once the gated clock is running and stable.
// PARAMETERS
//   IDLE_W    8   width of idle counter and CFG_IDLE_TH
//   WAKE_LAT  2   cycles spent in WAKE before WAKE_ACK rises (legal 1..15)
//   CNT_W     16  width of gating-event counter GATE_CNT
// PORTS
//   CLK_IN       in   1       free-running (ungated) clock
//   RST          in   1       reset, synchronous, active-high
//   CFG_EN       in   1       1 = autogating allowed
//   CFG_IDLE_TH  in   IDLE_W  idle cycles required before gating (0 = never gate)
//   BUSY         in   1       unit has work in flight
//   WAKE_REQ     in   1       level request to run the gated clock
//   TE_IN        in   1       scan test enable
//   GATE_EN      out  1       to GATED_CLK_CELL.EN
//   GATE_TE      out  1       to GATED_CLK_CELL.TE
//   WAKE_ACK     out  1       1 = gated clock running and usable
//   GATED        out  1       1 = clock currently gated
//   GATE_CNT     out  CNT_W   number of RUN->GATED transitions, saturating
// BEHAVIOUR
// - One clock (CLK_IN); reset is synchronous and active-high (RST).
// - Reset values:
//   - state=RUN, idle_cnt=0, GATE_EN=1, WAKE_ACK=1, GATED=0, GATE_CNT=0.
//   - A reset asserted in any state (incl. GATED/WAKE) returns to RUN with GATE_EN=1 at that edge.
// - GATE_TE = TE_IN (combinational pass-through). All other outputs are registered.
// - idle cycle = CFG_EN & ~BUSY & ~WAKE_REQ & ~TE_IN & (CFG_IDLE_TH != 0).
// - FSM states RUN, GATED, WAKE:
//   - RUN (GATE_EN=1, WAKE_ACK=1, GATED=0):
//     - idle cycle: idle_cnt += 1; otherwise idle_cnt <= 0.
//     - On the edge that samples an idle cycle with idle_cnt+1 >= CFG_IDLE_TH:
//       -> GATED, GATE_EN<=0, WAKE_ACK<=0, GATED<=1, GATE_CNT += 1 (holds at all-ones).
//     - CFG_IDLE_TH is compared live. Lowering it below idle_cnt gates on the next idle cycle.
//     - The counter never wraps, because the >= compare fires first.
//   - GATED (GATE_EN=0, WAKE_ACK=0, GATED=1):
//     - wake condition = BUSY | WAKE_REQ | TE_IN | ~CFG_EN.
//     - Wake condition sampled -> WAKE, GATE_EN<=1, GATED<=0, wake_cnt<=0.
//   - WAKE (GATE_EN=1, WAKE_ACK=0, GATED=0):
//     - wake_cnt += 1 each cycle. All inputs are ignored; the wake always completes.
//     - When wake_cnt == WAKE_LAT-1 -> RUN, WAKE_ACK<=1, idle_cnt<=0.
// - Latency:
//   - Gating: GATE_EN falls at the edge sampling the CFG_IDLE_TH-th consecutive idle cycle.
//   - Wake: GATE_EN rises 1 edge after the wake condition is sampled. WAKE_ACK rises WAKE_LAT edges later.
// - Handshake: requester holds WAKE_REQ until WAKE_ACK=1. WAKE_REQ in RUN only blocks/clears idle counting.
// - Simultaneous events:
//   - BUSY and the threshold in the same cycle: not idle, no gating.
//   - WAKE_REQ deasserted during WAKE: the wake still completes to RUN.
// - GATE_EN is driven only from a flop, so it is glitch-free into the latch-based cell.
// TESTING
// 1. RST=1 for 2 cycles, release, BUSY=1 -> GATE_EN=1, WAKE_ACK=1, GATED=0, GATE_CNT=0.
// 2. CFG_EN=1, TH=4, BUSY falls -> GATE_EN=0 and GATED=1 at the 4th edge; GATE_CNT=1.
//    BUSY pulse at idle cycle 3 restarts the count, so gating occurs 4 idle cycles later.
// 3. In GATED, WAKE_REQ=1 -> GATE_EN=1 next edge; WAKE_ACK=1 after 2 more edges (WAKE_LAT=2).
//    Drop WAKE_REQ inside WAKE -> still reaches RUN.
// 4. TH=0 or CFG_EN=0 with BUSY=0 for 300 cycles -> never gates.
//    CFG_EN 1->0 while GATED -> wake sequence runs.
// 5. TE_IN=1 -> GATE_TE=1 same cycle. TE_IN while GATED forces wake; no gating while TE_IN=1.
// 6. RST asserted mid-WAKE and mid-GATED -> next edge RUN, GATE_EN=1, GATE_CNT=0.
//    Force GATE_CNT to all-ones (CNT_W=4, 16 gate events) -> a further gate event holds 15.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// Idle-detect clock-gating controller for GATED_CLK_CELL (EN/TE).
// In: CLK_IN RST CFG_EN CFG_IDLE_TH BUSY WAKE_REQ TE_IN
// Out: GATE_EN GATE_TE WAKE_ACK GATED GATE_CNT
module clk_gate_ctrl #(
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic              CLK_IN,
  input  logic              RST,
  input  logic              CFG_EN,
  input  logic [IDLE_W-1:0] CFG_IDLE_TH,
  input  logic              BUSY,
  input  logic              WAKE_REQ,
  input  logic              TE_IN,
  output logic              GATE_EN,
  output logic              GATE_TE,
  output logic              WAKE_ACK,
  output logic              GATED,
  output logic [CNT_W-1:0]  GATE_CNT
);

  typedef enum logic [1:0] {
    S_RUN,
    S_GATED,
    S_WAKE
  } state_e;

  localparam logic [3:0] WAKE_LAST = 4'(WAKE_LAT - 1);

  state_e             state_q, state_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [3:0]         wake_cnt_q, wake_cnt_d;
  logic [CNT_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic               gate_en_q, gate_en_d;
  logic               wake_ack_q, wake_ack_d;
  logic               gated_q, gated_d;

  logic               idle;
  logic               wake_cond;
  logic               th_hit;

  assign idle = CFG_EN & ~BUSY & ~WAKE_REQ & ~TE_IN
              & (CFG_IDLE_TH != '0);
  assign wake_cond = BUSY | WAKE_REQ | TE_IN | ~CFG_EN;
  // One extra bit so idle_cnt+1 cannot overflow the compare.
  assign th_hit = ({1'b0, idle_cnt_q} + (IDLE_W+1)'(1))
               >= {1'b0, CFG_IDLE_TH};

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state_q    <= S_RUN;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      gate_cnt_q <= '0;
      gate_en_q  <= 1'b1;
      wake_ack_q <= 1'b1;
      gated_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      gate_cnt_q <= gate_cnt_d;
      gate_en_q  <= gate_en_d;
      wake_ack_q <= wake_ack_d;
      gated_q    <= gated_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    gate_cnt_d = gate_cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (idle) begin
          if (th_hit) begin
            state_d    = S_GATED;
            idle_cnt_d = '0;
            if (~&gate_cnt_q)
              gate_cnt_d = gate_cnt_q + 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      S_GATED: begin
        if (wake_cond) begin
          state_d    = S_WAKE;
          wake_cnt_d = '0;
        end
      end
      S_WAKE: begin
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = S_RUN;
          idle_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Outputs are decoded from the next state and then
  // registered, so GATE_EN comes straight off a flop.
  always_comb begin
    gate_en_d  = 1'b1;
    wake_ack_d = 1'b1;
    gated_d    = 1'b0;
    unique case (state_d)
      S_RUN: begin
        gate_en_d  = 1'b1;
        wake_ack_d = 1'b1;
        gated_d    = 1'b0;
      end
      S_GATED: begin
        gate_en_d  = 1'b0;
        wake_ack_d = 1'b0;
        gated_d    = 1'b1;
      end
      S_WAKE: begin
        gate_en_d  = 1'b1;
        wake_ack_d = 1'b0;
        gated_d    = 1'b0;
      end
      default: ;
    endcase
  end

  assign GATE_EN  = gate_en_q;
  assign GATE_TE  = TE_IN;
  assign WAKE_ACK = wake_ack_q;
  assign GATED    = gated_q;
  assign GATE_CNT = gate_cnt_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Testbench for clk_gate_ctrl: directed stimulus,
// cycle model plus hand-computed literal checks.
module tb_clk_gate_ctrl;

  localparam int IDLE_W   = 8;
  localparam int WAKE_LAT = 2;
  localparam int CNT_W    = 4;

  logic              clk;
  logic              RST;
  logic              CFG_EN;
  logic [IDLE_W-1:0] CFG_IDLE_TH;
  logic              BUSY;
  logic              WAKE_REQ;
  logic              TE_IN;
  logic              GATE_EN;
  logic              GATE_TE;
  logic              WAKE_ACK;
  logic              GATED;
  logic [CNT_W-1:0]  GATE_CNT;

  int n_chk = 0;
  int n_err = 0;

  clk_gate_ctrl #(
    .IDLE_W(IDLE_W),
    .WAKE_LAT(WAKE_LAT),
    .CNT_W(CNT_W)
  ) dut (
    .CLK_IN(clk),
    .RST(RST),
    .CFG_EN(CFG_EN),
    .CFG_IDLE_TH(CFG_IDLE_TH),
    .BUSY(BUSY),
    .WAKE_REQ(WAKE_REQ),
    .TE_IN(TE_IN),
    .GATE_EN(GATE_EN),
    .GATE_TE(GATE_TE),
    .WAKE_ACK(WAKE_ACK),
    .GATED(GATED),
    .GATE_CNT(GATE_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Model: clock is either gated, waking with some
  // cycles left, or running with a run of idle cycles.
  bit m_valid = 0;
  bit m_gated = 0;
  int m_wait  = 0;
  int m_run   = 0;
  int m_ev    = 0;
  int exp_cnt;
  bit m_idle;

  always @(posedge clk) begin
    m_idle = CFG_EN && !BUSY && !WAKE_REQ && !TE_IN
          && (CFG_IDLE_TH != 0);
    if (RST) begin
      m_valid = 1;
      m_gated = 0;
      m_wait  = 0;
      m_run   = 0;
      m_ev    = 0;
    end else if (m_gated) begin
      if (BUSY || WAKE_REQ || TE_IN || !CFG_EN) begin
        m_gated = 0;
        m_wait  = WAKE_LAT;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_run = 0;
    end else if (m_idle) begin
      m_run++;
      if (m_run >= int'(CFG_IDLE_TH)) begin
        m_gated = 1;
        m_ev++;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    #2;
    if (m_valid) begin
      exp_cnt = (m_ev > 15) ? 15 : m_ev;
      chk("m_gate_en", GATE_EN, !m_gated);
      chk("m_gated", GATED, m_gated);
      chk("m_wake_ack", WAKE_ACK,
          !m_gated && m_wait == 0);
      chk("m_gate_cnt", GATE_CNT, exp_cnt);
      chk("m_gate_te", GATE_TE, TE_IN);
    end
  end

  initial begin
    RST = 1; CFG_EN = 0; CFG_IDLE_TH = 0;
    BUSY = 1; WAKE_REQ = 0; TE_IN = 0;
    repeat (2) @(negedge clk);
    RST = 0;
    @(negedge clk);
    chk("rst_gate_en", GATE_EN, 1);
    chk("rst_wake_ack", WAKE_ACK, 1);
    chk("rst_gated", GATED, 0);
    chk("rst_cnt", GATE_CNT, 0);

    // gate after 4 idle cycles
    CFG_EN = 1; CFG_IDLE_TH = 4; BUSY = 0;
    repeat (3) @(negedge clk);
    chk("th4_not_yet", GATED, 0);
    @(negedge clk);
    chk("th4_gated", GATED, 1);
    chk("th4_gate_en", GATE_EN, 0);
    chk("th4_cnt", GATE_CNT, 1);

    // wake request, dropped inside WAKE
    WAKE_REQ = 1;
    @(negedge clk);
    chk("wk_gate_en", GATE_EN, 1);
    chk("wk_ack0", WAKE_ACK, 0);
    WAKE_REQ = 0;
    @(negedge clk);
    chk("wk_ack1", WAKE_ACK, 0);
    @(negedge clk);
    chk("wk_ack2", WAKE_ACK, 1);
    BUSY = 1;

    // BUSY pulse at idle cycle 3 restarts count
    @(negedge clk);
    BUSY = 0;
    repeat (2) @(negedge clk);
    BUSY = 1;
    @(negedge clk);
    BUSY = 0;
    repeat (3) @(negedge clk);
    chk("pulse_not_yet", GATED, 0);
    @(negedge clk);
    chk("pulse_gated", GATED, 1);
    chk("pulse_cnt", GATE_CNT, 2);
    BUSY = 1;
    @(negedge clk);
    chk("busy_wake", GATE_EN, 1);
    repeat (2) @(negedge clk);
    chk("busy_ack", WAKE_ACK, 1);

    // BUSY together with threshold: no gating
    BUSY = 0;
    repeat (3) @(negedge clk);
    BUSY = 1;
    @(negedge clk);
    chk("busy_th", GATED, 0);

    // TH=0 and CFG_EN=0 never gate
    BUSY = 0; CFG_IDLE_TH = 0;
    repeat (300) @(negedge clk);
    chk("th0_never", GATED, 0);
    CFG_IDLE_TH = 4; CFG_EN = 0;
    repeat (300) @(negedge clk);
    chk("cfg0_never", GATED, 0);
    chk("cfg0_cnt", GATE_CNT, 2);
    CFG_EN = 1;
    repeat (4) @(negedge clk);
    chk("cfg1_gated", GATED, 1);
    CFG_EN = 0;
    @(negedge clk);
    chk("cfg0_wake", GATE_EN, 1);
    repeat (2) @(negedge clk);
    chk("cfg0_ack", WAKE_ACK, 1);

    // scan test enable
    TE_IN = 1;
    #1 chk("te_pass1", GATE_TE, 1);
    TE_IN = 0;
    #1 chk("te_pass0", GATE_TE, 0);
    @(negedge clk);
    CFG_EN = 1;
    repeat (4) @(negedge clk);
    chk("te_pre_gated", GATED, 1);
    chk("te_pre_cnt", GATE_CNT, 4);
    TE_IN = 1;
    @(negedge clk);
    chk("te_wake", GATE_EN, 1);
    repeat (12) @(negedge clk);
    chk("te_no_gate", GATED, 0);
    chk("te_ack", WAKE_ACK, 1);
    TE_IN = 0; BUSY = 1;

    // threshold lowered below idle count
    @(negedge clk);
    CFG_IDLE_TH = 8; BUSY = 0;
    repeat (5) @(negedge clk);
    chk("live_not_yet", GATED, 0);
    CFG_IDLE_TH = 3;
    @(negedge clk);
    chk("live_gated", GATED, 1);
    chk("live_cnt", GATE_CNT, 5);
    WAKE_REQ = 1; CFG_IDLE_TH = 4;
    repeat (3) @(negedge clk);
    chk("live_ack", WAKE_ACK, 1);
    WAKE_REQ = 0; BUSY = 1;

    // reset mid-GATED and mid-WAKE
    @(negedge clk);
    BUSY = 0;
    repeat (4) @(negedge clk);
    chk("r6_gated", GATE_CNT, 6);
    RST = 1;
    @(negedge clk);
    chk("rg_gate_en", GATE_EN, 1);
    chk("rg_gated", GATED, 0);
    chk("rg_cnt", GATE_CNT, 0);
    RST = 0;
    repeat (4) @(negedge clk);
    chk("rg_regate", GATE_CNT, 1);
    BUSY = 1;
    @(negedge clk);
    chk("rw_in_wake", WAKE_ACK, 0);
    RST = 1;
    @(negedge clk);
    chk("rw_ack", WAKE_ACK, 1);
    chk("rw_cnt", GATE_CNT, 0);
    RST = 0;

    // saturate the 4-bit gate counter
    CFG_IDLE_TH = 1;
    for (int i = 0; i < 16; i++) begin
      BUSY = 0;
      @(negedge clk);
      BUSY = 1;
      repeat (3) @(negedge clk);
      if (i == 14) chk("sat15", GATE_CNT, 15);
    end
    chk("sat_hold", GATE_CNT, 15);
    chk("sat_run", GATED, 0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
